// File: rtl/r4_pkg.sv
// Shared R4 execute-stage types and constants for the shared-alu controller.
package r4_pkg;

   localparam int unsigned R4_XLEN = 32;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_ctrl_state_t;

   typedef struct packed {
      logic [R4_XLEN-1:0] in1;
      logic [R4_XLEN-1:0] in2;
      logic [2:0]         funct3;
      logic [6:0]         funct7;
   } alu_op_t;

   // Only the base encodings plus sub/sra are accepted by the shared alu.
   function automatic logic op_is_legal(input logic [2:0] f3, input logic [6:0] f7);
      return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
   endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational RV32 integer alu; flags are derived from the result.
module alu
   import r4_pkg::*;
#(
   parameter int unsigned XLEN = R4_XLEN
) (
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   output logic [XLEN-1:0] result,
   output logic            negative,
   output logic            zero
);

   localparam int unsigned SHW = $clog2(XLEN);

   logic [SHW-1:0]          w_shamt;
   logic signed [XLEN-1:0]  w_sra;

   assign w_shamt = in2[SHW-1:0];
   assign w_sra   = $signed(in1) >>> w_shamt;

   // Operation select on funct3, funct7 picks sub/sra.
   always_comb begin
      result = '0;
      case (funct3)
         F3_ADD:  result = (funct7 == F7_ALT) ? (in1 - in2) : (in1 + in2);
         F3_SLL:  result = in1 << w_shamt;
         F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
         F3_SLTU: result = {{(XLEN-1){1'b0}}, (in1 < in2)};
         F3_XOR:  result = in1 ^ in2;
         F3_SR:   result = (funct7 == F7_ALT) ? w_sra : (in1 >> w_shamt);
         F3_OR:   result = in1 | in2;
         F3_AND:  result = in1 & in2;
         default: result = '0;
      endcase
   end

   assign negative = result[XLEN-1];
   assign zero     = (result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin shared-alu controller: IDLE grants one requester, EXEC evaluates the
// latched op, RESP holds the registered response until it is accepted.
module alu_share_ctrl
   import r4_pkg::*;
#(
   parameter  int unsigned XLEN = R4_XLEN,
   parameter  int unsigned NREQ = 2,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XLEN-1:0] req_in1,
   input  logic [NREQ*XLEN-1:0] req_in2,
   input  logic [NREQ*3-1:0]    req_funct3,
   input  logic [NREQ*7-1:0]    req_funct7,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [XLEN-1:0]      rsp_result,
   output logic                 rsp_negative,
   output logic                 rsp_zero,
   output logic                 rsp_illegal
);

   alu_ctrl_state_t r_state, w_next;
   alu_op_t         r_op;
   logic [IDW-1:0]  r_id;
   logic [IDW-1:0]  r_last_grant;

   logic            w_any;
   logic [IDW-1:0]  w_grant;
   logic            w_accept;
   logic [XLEN-1:0] w_sel_in1, w_sel_in2;
   logic [2:0]      w_sel_f3;
   logic [6:0]      w_sel_f7;
   logic [XLEN-1:0] w_alu_result;
   logic            w_alu_negative, w_alu_zero;
   logic            w_illegal;

   // First valid requester after 'last', wrapping modulo NREQ; MSB flags a hit.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [IDW-1:0]  last);
      logic           found;
      logic [IDW-1:0] pick, cand;
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDW'((32'(last) + k) % NREQ);
         if (!found && valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      return {found, pick};
   endfunction

   assign {w_any, w_grant} = rr_pick(req_valid, r_last_grant);

   // Operand mux for the granted requester.
   always_comb begin
      w_sel_in1 = '0;
      w_sel_in2 = '0;
      w_sel_f3  = '0;
      w_sel_f7  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_grant == IDW'(i)) begin
            w_sel_in1 = req_in1[i*XLEN +: XLEN];
            w_sel_in2 = req_in2[i*XLEN +: XLEN];
            w_sel_f3  = req_funct3[i*3 +: 3];
            w_sel_f7  = req_funct7[i*7 +: 7];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and the grant strobe; req_ready only ever rises in IDLE.
   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      w_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               req_ready[w_grant] = 1'b1;
               w_accept           = 1'b1;
               w_next             = EXEC;
            end
         end
         EXEC:    w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   alu #(.XLEN(XLEN)) u_alu (
      .in1      (r_op.in1),
      .in2      (r_op.in2),
      .funct3   (r_op.funct3),
      .funct7   (r_op.funct7),
      .result   (w_alu_result),
      .negative (w_alu_negative),
      .zero     (w_alu_zero)
   );

   assign w_illegal = !op_is_legal(r_op.funct3, r_op.funct7);

   // Operand latch on grant, response capture at the end of EXEC, release on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op         <= '0;
         r_id         <= '0;
         r_last_grant <= IDW'(NREQ - 1);
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_result   <= '0;
         rsp_negative <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_illegal  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op         <= '{in1: w_sel_in1, in2: w_sel_in2, funct3: w_sel_f3, funct7: w_sel_f7};
            r_id         <= w_grant;
            r_last_grant <= w_grant;
         end
         if (r_state == EXEC) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= r_id;
            rsp_illegal  <= w_illegal;
            rsp_result   <= w_illegal ? '0   : w_alu_result;
            rsp_negative <= w_illegal ? 1'b0 : w_alu_negative;
            rsp_zero     <= w_illegal ? 1'b1 : w_alu_zero;
         end
         if ((r_state == RESP) && rsp_ready) rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed bench for alu_share_ctrl against a transaction-level model.
module tb_alu_share_ctrl;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREQ = 3;
   localparam int unsigned IDW  = 2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*XLEN-1:0] req_in1, req_in2;
   logic [NREQ*3-1:0]    req_funct3;
   logic [NREQ*7-1:0]    req_funct7;
   logic                 rsp_valid, rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [XLEN-1:0]      rsp_result;
   logic                 rsp_negative, rsp_zero, rsp_illegal;

   alu_share_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_in1      (req_in1),
      .req_in2      (req_in2),
      .req_funct3   (req_funct3),
      .req_funct7   (req_funct7),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_negative (rsp_negative),
      .rsp_zero     (rsp_zero),
      .rsp_illegal  (rsp_illegal)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: m_phase counts where the single outstanding op is (0 none, 1 computing, 2 offered).
   int          m_phase, m_last, m_granted, m_id, e_id;
   logic [31:0] m_a, m_b, e_res;
   logic [2:0]  m_f3;
   logic [6:0]  m_f7;
   logic        e_neg, e_zero, e_ill;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns {illegal, negative, zero, result} from the RV32 definitions.
   function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7);
      logic        legal;
      logic [31:0] r;
      int          sh;
      legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      sh = int'(b[4:0]);
      case (f3)
         3'd0: r = (f7 == 7'h20) ? (a + ~b + 32'd1) : (a + b);
         3'd1: r = a << sh;
         3'd2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: r = (a >> sh) | (((f7 == 7'h20) && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      if (!legal) return {1'b1, 1'b0, 1'b1, 32'd0};
      return {1'b0, r[31], (r == 32'd0), r};
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic [6:0] f7);
      req_valid[r]           = 1'b1;
      req_in1[r*32 +: 32]    = a;
      req_in2[r*32 +: 32]    = b;
      req_funct3[r*3 +: 3]   = f3;
      req_funct7[r*7 +: 7]   = f7;
   endtask

   // One clock: check outputs against the model before the edge, then advance the model.
   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      int              g, idx;
      #1;
      exp_rdy = '0;
      g = -1;
      if (m_phase == 0) begin
         for (int k = 1; k <= int'(NREQ); k++) begin
            idx = (m_last + k) % int'(NREQ);
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase == 2) begin
         chk("rsp_id",       64'(rsp_id),       64'(e_id));
         chk("rsp_result",   64'(rsp_result),   64'(e_res));
         chk("rsp_negative", 64'(rsp_negative), 64'(e_neg));
         chk("rsp_zero",     64'(rsp_zero),     64'(e_zero));
         chk("rsp_illegal",  64'(rsp_illegal),  64'(e_ill));
      end
      m_granted = g;
      case (m_phase)
         0: if (g >= 0) begin
               m_a = req_in1[g*32 +: 32];
               m_b = req_in2[g*32 +: 32];
               m_f3 = req_funct3[g*3 +: 3];
               m_f7 = req_funct7[g*7 +: 7];
               m_id = g;
               m_last = g;
               m_phase = 1;
            end
         1: begin
               {e_ill, e_neg, e_zero, e_res} = ref_op(m_a, m_b, m_f3, m_f7);
               e_id = m_id;
               m_phase = 2;
            end
         default: if (rsp_ready) m_phase = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_phase = 0;
      m_last = int'(NREQ) - 1;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_id",    64'(rsp_id), 64'd0);
      chk("rst_result",    64'(rsp_result), 64'd0);
      chk("rst_flags",     64'({rsp_negative, rsp_zero, rsp_illegal}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Single op with the response held off for 'hold' extra cycles; flags = {ill,neg,zero}.
   task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] exp_res, input logic [2:0] exp_flags, input int hold);
      set_req(r, a, b, f3, f7);
      rsp_ready = 1'b0;
      step();
      req_valid[r] = 1'b0;
      step();
      for (int h = 0; h < hold; h++) begin
         chk("dir_hold_result", 64'(rsp_result), 64'(exp_res));
         req_valid[(r + 1) % int'(NREQ)] = 1'b1;
         step();
      end
      req_valid = '0;
      chk("dir_id",     64'(rsp_id), 64'(r));
      chk("dir_result", 64'(rsp_result), 64'(exp_res));
      chk("dir_flags",  64'({rsp_illegal, rsp_negative, rsp_zero}), 64'(exp_flags));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      step();
   endtask

   initial begin
      int order [4];
      int n_grant;
      req_valid  = '0;
      req_in1    = '0;
      req_in2    = '0;
      req_funct3 = '0;
      req_funct7 = '0;
      rsp_ready  = 1'b0;
      m_granted  = -1;
      do_reset();

      run_op(0, 32'h0000_000F, 32'h0000_00F0, 3'b000, 7'h00, 32'h0000_00FF, 3'b000, 0);
      run_op(1, 32'h0000_0000, 32'h0000_0001, 3'b000, 7'h20, 32'hFFFF_FFFF, 3'b010, 0);
      run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 7'h00, 32'h0000_0000, 3'b001, 0);
      run_op(0, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b111, 7'h00, 32'h0F00_0F00, 3'b000, 5);
      run_op(2, $urandom, $urandom, 3'b111, 7'h20, 32'h0000_0000, 3'b101, 0);

      // Contention between requesters 0 and 1 (last grant was 2).
      set_req(0, pick_val(), pick_val(), 3'($urandom_range(0, 7)), 7'h00);
      set_req(1, pick_val(), pick_val(), 3'($urandom_range(0, 7)), 7'h00);
      rsp_ready = 1'b1;
      n_grant = 0;
      for (int c = 0; c < 20 && n_grant < 4; c++) begin
         step();
         if (m_granted >= 0) begin
            order[n_grant] = m_granted;
            n_grant++;
            set_req(m_granted, pick_val(), pick_val(), 3'($urandom_range(0, 7)), 7'h00);
         end
      end
      chk("contend_count", 64'(n_grant), 64'd4);
      for (int i = 0; i < n_grant; i++) chk("contend_order", 64'(order[i]), 64'(i % 2));
      req_valid = '0;
      repeat (4) step();

      // Asynchronous reset while an op sits in EXEC.
      set_req(1, 32'h1234_5678, 32'h1, 3'b000, 7'h00);
      step();
      req_valid = '0;
      #2;
      do_reset();
      set_req(0, 32'h5, 32'h3, 3'b000, 7'h00);
      set_req(1, 32'h7, 32'h3, 3'b000, 7'h00);
      step();
      chk("post_reset_grant", 64'(m_granted), 64'd0);
      req_valid = '0;
      repeat (4) step();

      // Randomized traffic with backpressure; requesters hold until granted.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               set_req(i, pick_val(), pick_val(), 3'($urandom_range(0, 7)),
                       ($urandom_range(0, 9) < 5) ? 7'h00 :
                       ($urandom_range(0, 4) < 4) ? 7'h20 : 7'($urandom));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
         if (m_granted >= 0) req_valid[m_granted] = 1'b0;
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
